// File: rtl/rifl_tx_user_fifo.sv
// rifl_tx_user_fifo: user-side AXI4-Stream buffer in front of the core TX port.
// First-word-fall-through FIFO with optional store-and-forward release, so a
// packet reaches the core without mid-packet valid gaps. Occupancy, packet
// count and an almost-full flag are exported for flow-control monitoring.
module rifl_tx_user_fifo #(
    parameter int DWIDTH       = 240,
    parameter int DEPTH        = 16,
    parameter bit STORE_FWD    = 1'b0,
    parameter int AFULL_THRESH = 12
) (
    input  logic                       tx_frame_clk,
    input  logic                       tx_frame_rst_n,
    input  logic [DWIDTH-1:0]          s_axis_tdata,
    input  logic [DWIDTH/8-1:0]        s_axis_tkeep,
    input  logic                       s_axis_tlast,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [DWIDTH-1:0]          m_axis_tdata,
    output logic [DWIDTH/8-1:0]        m_axis_tkeep,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [$clog2(DEPTH):0]     pkt_cnt,
    output logic                       almost_full,
    output logic                       cut_thru_forced
);

    localparam int AW = $clog2(DEPTH);
    localparam int KW = DWIDTH / 8;

    typedef struct packed {
        logic              last;
        logic [KW-1:0]     keep;
        logic [DWIDTH-1:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [AW:0]   occ_q, occ_d;
    logic [AW:0]   pkt_q, pkt_d;
    logic          rdy_q;
    logic          in_pkt;
    logic          forced_q;
    logic          full, empty;
    logic          wr_en, rd_en;
    logic          wr_last, rd_last;

    // Full when the pointers differ only in the wrap bit, empty when equal.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    // Input ready is purely registered state: held low through reset, then !full.
    assign s_axis_tready = rdy_q && !full;
    assign wr_en         = s_axis_tvalid && s_axis_tready;
    assign wr_last       = wr_en && s_axis_tlast;

    // Head entry falls through to the output; it only changes on a read.
    assign head          = mem[rd_ptr[AW-1:0]];
    assign m_axis_tdata  = head.data;
    assign m_axis_tkeep  = head.keep;
    assign m_axis_tlast  = head.last;
    assign rd_en         = m_axis_tvalid && m_axis_tready;
    assign rd_last       = rd_en && head.last;

    assign occupancy       = occ_q;
    assign pkt_cnt         = pkt_q;
    assign cut_thru_forced = forced_q;

    // Output valid: cut-through releases any stored beat; store-and-forward
    // waits for a complete packet, a full FIFO (oversized packet), or an
    // already started packet that must drain without gaps.
    always_comb begin
        if (STORE_FWD)
            m_axis_tvalid = !empty && ((pkt_q != '0) || full || in_pkt);
        else
            m_axis_tvalid = !empty;
    end

    // Next-state occupancy and packet count; simultaneous in/out cancels.
    always_comb begin
        occ_d = occ_q;
        if (wr_en && !rd_en)
            occ_d = occ_q + (AW+1)'(1);
        else if (!wr_en && rd_en)
            occ_d = occ_q - (AW+1)'(1);

        pkt_d = pkt_q;
        if (wr_last && !rd_last)
            pkt_d = pkt_q + (AW+1)'(1);
        else if (!wr_last && rd_last)
            pkt_d = pkt_q - (AW+1)'(1);
    end

    // Storage array: not reset, contents only matter behind a valid pointer.
    always_ff @(posedge tx_frame_clk) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= '{last: s_axis_tlast, keep: s_axis_tkeep, data: s_axis_tdata};
    end

    // Pointers, counters and status flags.
    always_ff @(posedge tx_frame_clk or negedge tx_frame_rst_n) begin
        if (!tx_frame_rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ_q       <= '0;
            pkt_q       <= '0;
            rdy_q       <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            rdy_q       <= 1'b1;
            if (wr_en)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en)
                rd_ptr <= rd_ptr + (AW+1)'(1);
            occ_q       <= occ_d;
            pkt_q       <= pkt_d;
            almost_full <= (int'(occ_d) >= AFULL_THRESH);
        end
    end

    // Packet-in-flight tracker: keeps an opened packet flowing to its tlast.
    always_ff @(posedge tx_frame_clk or negedge tx_frame_rst_n) begin
        if (!tx_frame_rst_n)
            in_pkt <= 1'b0;
        else if (rd_en)
            in_pkt <= !head.last;
    end

    // Sticky flag: store-and-forward had to fall back to cut-through.
    always_ff @(posedge tx_frame_clk or negedge tx_frame_rst_n) begin
        if (!tx_frame_rst_n)
            forced_q <= 1'b0;
        else if (STORE_FWD && full && (pkt_q == '0))
            forced_q <= 1'b1;
    end

endmodule

// File: tb/tb_rifl_tx_user_fifo.sv
// Directed bench for rifl_tx_user_fifo: one cut-through and one
// store-and-forward instance, checked against a beat queue and fixed values.
module tb_rifl_tx_user_fifo;

    localparam int DW    = 240;
    localparam int KW    = DW / 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int EW    = DW + KW + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] s_tdata = '0;
    logic [KW-1:0] s_tkeep = '0;
    logic          s_tlast = 1'b0;
    logic [1:0]    s_tvalid = '0;
    logic [1:0]    m_tready = '0;

    logic          s_tready [2];
    logic [DW-1:0] m_tdata  [2];
    logic [KW-1:0] m_tkeep  [2];
    logic          m_tlast  [2];
    logic          m_tvalid [2];
    logic [CW-1:0] occ      [2];
    logic [CW-1:0] pkt      [2];
    logic          afull    [2];
    logic          forced   [2];

    rifl_tx_user_fifo #(.DWIDTH(DW), .DEPTH(DEPTH), .STORE_FWD(1'b0), .AFULL_THRESH(12)) u_ct (
        .tx_frame_clk(clk), .tx_frame_rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]),
        .m_axis_tdata(m_tdata[0]), .m_axis_tkeep(m_tkeep[0]), .m_axis_tlast(m_tlast[0]),
        .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready[0]),
        .occupancy(occ[0]), .pkt_cnt(pkt[0]), .almost_full(afull[0]),
        .cut_thru_forced(forced[0]));

    rifl_tx_user_fifo #(.DWIDTH(DW), .DEPTH(DEPTH), .STORE_FWD(1'b1), .AFULL_THRESH(12)) u_sf (
        .tx_frame_clk(clk), .tx_frame_rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]),
        .m_axis_tdata(m_tdata[1]), .m_axis_tkeep(m_tkeep[1]), .m_axis_tlast(m_tlast[1]),
        .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready[1]),
        .occupancy(occ[1]), .pkt_cnt(pkt[1]), .almost_full(afull[1]),
        .cut_thru_forced(forced[1]));

    int n_run  = 0;
    int n_fail = 0;
    logic [EW-1:0] exp_q[$];

    // Single comparison point for the whole bench.
    task automatic chk(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int nlast();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i][EW-1]) n++;
        return n;
    endfunction

    // One clock on instance s: drive, score handshakes, then check status.
    task automatic step(input int s, input logic v, input logic [DW-1:0] d,
                        input logic l, input logic r, output logic acc);
        logic [EW-1:0] e;
        s_tdata = d;
        s_tkeep = ~d[KW-1:0];
        s_tlast = l;
        s_tvalid = '0;
        s_tvalid[s] = v;
        m_tready = '0;
        m_tready[s] = r;
        #1;
        acc = v && s_tready[s];
        if (m_tvalid[s] && r) begin
            if (exp_q.size() == 0)
                chk("spurious_beat", 1'b1, 1'b0);
            else begin
                e = exp_q.pop_front();
                chk("beat", {m_tlast[s], m_tkeep[s], m_tdata[s]}, e);
            end
        end
        if (acc) exp_q.push_back({l, ~d[KW-1:0], d});
        @(posedge clk); #1;
        chk("occ", occ[s], exp_q.size());
        chk("pkt", pkt[s], nlast());
        chk("afull", afull[s], exp_q.size() >= 12);
    endtask

    task automatic drain(input int s);
        logic a;
        int n = 0;
        while (exp_q.size() != 0 && n < 64) begin
            step(s, 1'b0, '0, 1'b0, 1'b1, a);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_vld", m_tvalid[s], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic a;
        int idx, cyc;
        logic l;

        // Reset state
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_rdy", s_tready[i], 1'b0);
            chk("rst_vld", m_tvalid[i], 1'b0);
            chk("rst_occ", occ[i], 0);
            chk("rst_pkt", pkt[i], 0);
            chk("rst_af",  afull[i], 1'b0);
            chk("rst_frc", forced[i], 1'b0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_rdy0", s_tready[0], 1'b1);
        chk("rel_rdy1", s_tready[1], 1'b1);

        // Cut-through, 3 beats, one-cycle latency
        step(0, 1'b1, 'h1, 1'b0, 1'b1, a);
        chk("t1_lat_v", m_tvalid[0], 1'b1);
        chk("t1_lat_d", m_tdata[0], 'h1);
        step(0, 1'b1, 'h2, 1'b0, 1'b1, a);
        chk("t1_d2", m_tdata[0], 'h2);
        step(0, 1'b1, 'h3, 1'b1, 1'b1, a);
        chk("t1_d3", m_tdata[0], 'h3);
        chk("t1_l3", m_tlast[0], 1'b1);
        drain(0);

        // Fill to 16 with no reads, then read-while-full
        for (int i = 0; i < 16; i++) step(0, 1'b1, 'h100 + i, 1'b0, 1'b0, a);
        chk("t2_full_rdy", s_tready[0], 1'b0);
        chk("t2_full_occ", occ[0], 16);
        step(0, 1'b1, 'h999, 1'b0, 1'b1, a);
        chk("t2_no_wr", a, 1'b0);
        chk("t2_occ15", occ[0], 15);
        drain(0);

        // Store-and-forward, 4-beat packet
        for (int i = 0; i < 4; i++) begin
            step(1, 1'b1, 'h10 + i, i == 3, 1'b1, a);
            chk("t3_hold", m_tvalid[1], i == 3);
        end
        for (int i = 0; i < 4; i++) begin
            chk("t3_nogap", m_tvalid[1], 1'b1);
            step(1, 1'b0, '0, 1'b0, 1'b1, a);
        end
        chk("t3_pkt0", pkt[1], 0);
        chk("t3_vld0", m_tvalid[1], 1'b0);
        chk("t3_frc0", forced[1], 1'b0);

        // Store-and-forward, 20-beat packet exceeds depth
        idx = 0;
        cyc = 0;
        while (idx < 20 && cyc < 100) begin
            step(1, 1'b1, 'h20 + idx, idx == 19, 1'b1, a);
            if (a) idx++;
            if (idx < 16) chk("t4_hold", m_tvalid[1], 1'b0);
            cyc++;
        end
        chk("t4_sent", idx, 20);
        drain(1);
        chk("t4_forced", forced[1], 1'b1);
        chk("t4_ct_noforce", forced[0], 1'b0);

        // Continuous traffic, random tlast, toggled ready, several wraps
        idx = 0;
        cyc = 0;
        while ((idx < 40 || exp_q.size() != 0) && cyc < 400) begin
            l = ($urandom_range(0, 3) == 0);
            step(0, idx < 40, 'h1000 + idx, l, (cyc % 3) != 2, a);
            if (a) idx++;
            cyc++;
        end
        chk("t5_sent", idx, 40);
        chk("t5_empty", exp_q.size(), 0);

        // Reset with 5 beats buffered
        for (int i = 0; i < 5; i++) step(0, 1'b1, 'h50 + i, 1'b0, 1'b0, a);
        s_tvalid = '0;
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        chk("t6_vld", m_tvalid[0], 1'b0);
        chk("t6_occ", occ[0], 0);
        chk("t6_pkt", pkt[0], 0);
        chk("t6_rdy", s_tready[0], 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t6_rel_rdy", s_tready[0], 1'b1);
        step(0, 1'b1, 'hA, 1'b1, 1'b1, a);
        chk("t6_first_v", m_tvalid[0], 1'b1);
        chk("t6_first_d", m_tdata[0], 'hA);
        drain(0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/rifl_tx_user_fifo.md
Name: rifl_tx_user_fifo

Overview:
- User-side AXI4-Stream buffer in the tx_frame_clk domain, directly upstream of the core TX user interface (rifl_core_tx_*).
- Absorbs user bursts and core backpressure (pause/retransmit stalls).
- Optional store-and-forward mode: a packet is released only once it is completely buffered, so the core never sees a mid-packet valid gap.
- Exports occupancy and packet-count status for flow-control monitoring.

Parameters:
- DWIDTH, 240, data width; equals N_CHANNEL*PAYLOAD_WIDTH of the core; must be a multiple of 8.
- DEPTH, 16, entries; power of two, >= 4.
- STORE_FWD, 0, 0 = cut-through, 1 = store-and-forward.
- AFULL_THRESH, 12, almost_full asserts when occupancy >= this value; 1..DEPTH.

Ports:
- tx_frame_clk  in  1  sole clock.
- tx_frame_rst_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  DWIDTH  user data.
- s_axis_tkeep  in  DWIDTH/8  byte enables.
- s_axis_tlast  in  1  end of packet.
- s_axis_tvalid  in  1  user valid.
- s_axis_tready  out  1  FIFO can accept.
- m_axis_tdata  out  DWIDTH  to rifl_core_tx_tdata.
- m_axis_tkeep  out  DWIDTH/8  to rifl_core_tx_tkeep.
- m_axis_tlast  out  1  to rifl_core_tx_tlast.
- m_axis_tvalid  out  1  to rifl_core_tx_tvalid.
- m_axis_tready  in  1  from rifl_core_tx_tready.
- occupancy  out  $clog2(DEPTH)+1  stored entries.
- pkt_cnt  out  $clog2(DEPTH)+1  complete packets (tlast beats) stored.
- almost_full  out  1  occupancy >= AFULL_THRESH.
- cut_thru_forced  out  1  sticky: store-and-forward overridden by a full FIFO.

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr, rd_ptr, occupancy, pkt_cnt and cut_thru_forced = 0.
  - s_axis_tready = 0 while reset is asserted, 1 from the first clock after release.
  - m_axis_tvalid = 0, almost_full = 0.
  - Memory contents are not reset; m_axis_tdata, m_axis_tkeep and m_axis_tlast are don't-care while m_axis_tvalid = 0.
- Storage:
  - DEPTH-entry array of {tlast, tkeep, tdata}.
  - Pointers are $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty.
  - full = (ptrs differ only in MSB); empty = (ptrs equal).
- Write: when s_axis_tvalid && s_axis_tready, store the entry at wr_ptr and increment wr_ptr, wrapping modulo 2*DEPTH.
- s_axis_tready = !full. It depends only on registered state; no combinational path from m_axis_tready. When full, no write occurs even if a read happens in the same cycle.
- Read: first-word-fall-through. m_axis_tdata/tkeep/tlast are taken from mem[rd_ptr]. When m_axis_tvalid && m_axis_tready, increment rd_ptr.
- Latency: a beat written in cycle N is visible on m_axis in cycle N+1 (cut-through). No combinational path from s_axis to m_axis.
- m_axis_tvalid:
  - STORE_FWD=0: !empty.
  - STORE_FWD=1: !empty && (pkt_cnt != 0 || full || in_pkt).
  - in_pkt is a register. It sets on a handshaked non-last output beat and clears on a handshaked last beat. Once a packet starts, it drains without gaps even if pkt_cnt has already reached 0.
- Full override: if full && pkt_cnt == 0 in store-and-forward mode (packet larger than DEPTH), forward in cut-through and set cut_thru_forced (sticky until reset).
- AXI-Stream rule: once m_axis_tvalid asserts, it and the data stay stable until the handshake (guaranteed because only the head entry is read).
- occupancy: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
- pkt_cnt: +1 on a written tlast beat, -1 on a read tlast beat, unchanged when both occur in the same cycle.
- almost_full is registered from the next-state occupancy, so it is exact in the same cycle as occupancy.
- Boundary conditions:
  - Empty with simultaneous write: no read that cycle; valid appears next cycle.
  - Pointer wrap at DEPTH: pointer MSB toggles; data order is preserved.
  - Reset mid-packet: all buffered data is discarded; the partial packet is lost with no output.
- tkeep is passed through unmodified; no tkeep/tlast legality checks.

Test Plan:
- STORE_FWD=0: write 3 beats (tdata 0x1, 0x2, 0x3; tlast on 0x3), m_axis_tready=1 -> m_axis shows 0x1 one cycle after the first write, then 0x2, 0x3 on consecutive cycles; occupancy peaks at 1; pkt_cnt returns to 0.
- Fill with m_axis_tready=0, 16 non-last beats -> s_axis_tready=0 after the 16th write, occupancy=16, almost_full asserted from occupancy=12; then release with ready=1 -> beats drain in order with no loss.
- STORE_FWD=1: 4-beat packet with tready=1 -> m_axis_tvalid stays 0 until the cycle after the tlast write, then 4 back-to-back beats; pkt_cnt goes 1->0 on the last read.
- STORE_FWD=1: 20-beat packet, DEPTH=16 -> at full, forwarding starts, cut_thru_forced=1, all 20 beats delivered in order with tlast on beat 20.
- Continuous simultaneous read and write with 40 beats and random tlast (tready toggled) -> wrap exercised several times; output stream equals input stream; pkt_cnt equals the number of buffered tlast beats every cycle.
- Assert tx_frame_rst_n low with 5 beats buffered -> next cycle m_axis_tvalid=0, occupancy=0, pkt_cnt=0, s_axis_tready=0; after release, s_axis_tready=1 and a new beat 0xA appears as the first output.
